// File: rtl/x_top_uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// x_top_uart_arb_pkg
// Shared types and constants for the packet-level UART transmit arbiter.
//   arb_state_t     : FSM states of the arbiter (IDLE, TAG, DATA)
//   ARB_TAG_PREFIX  : upper nibble of the tag byte sent ahead of a packet
//   ARB_CNT_W       : width of the per-packet byte counter
// ---------------------------------------------------------------------------
package x_top_uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic [7:0] ARB_TAG_PREFIX = 8'hA0;
  localparam int         ARB_CNT_W      = 8;

endpackage

// File: rtl/x_top_uart_tx_arb_if.sv
// ---------------------------------------------------------------------------
// x_top_uart_tx_arb_if
// Byte-stream bundle between p_n requesters, the arbiter and the transmitter.
//   i_valid  [p_n]   : per-requester byte valid
//   i_data   [8*p_n] : per-requester byte, requester k in bits [8k+7:8k]
//   i_last   [p_n]   : per-requester end-of-packet flag
//   o_accept [p_n]   : per-requester byte taken this cycle
//   o_valid          : byte valid towards the transmitter
//   o_data   [8]     : byte towards the transmitter
//   i_accept         : transmitter took the byte
// Modports:
//   slave  : the arbiter's view
//   master : the requester/transmitter side (testbench)
// ---------------------------------------------------------------------------
interface x_top_uart_tx_arb_if #(
  parameter int p_n = 4
);

  logic [p_n-1:0]   i_valid;
  logic [8*p_n-1:0] i_data;
  logic [p_n-1:0]   i_last;
  logic [p_n-1:0]   o_accept;
  logic             o_valid;
  logic [7:0]       o_data;
  logic             i_accept;

  modport slave (
    input  i_valid, i_data, i_last, i_accept,
    output o_accept, o_valid, o_data
  );

  modport master (
    output i_valid, i_data, i_last, i_accept,
    input  o_accept, o_valid, o_data
  );

endinterface

// File: rtl/x_top_uart_arb_rr.sv
// ---------------------------------------------------------------------------
// x_top_uart_arb_rr
// Combinational round-robin picker, shared with other arbiters.
//   req     [p_n] : request vector
//   ptr           : index where the search starts
//   gnt_idx       : lowest requesting index >= ptr, else lowest requesting index
//   any           : at least one request is present
// ---------------------------------------------------------------------------
module x_top_uart_arb_rr
  import x_top_uart_arb_pkg::*;
#(
  parameter  int p_n = 4,
  localparam int gw  = (p_n > 1) ? $clog2(p_n) : 1
) (
  input  logic [p_n-1:0] req,
  input  logic [gw-1:0]  ptr,
  output logic [gw-1:0]  gnt_idx,
  output logic           any
);

  // Two descending scans: the first finds the lowest requester overall (the
  // wrap-around fallback), the second overrides it with the lowest requester
  // at or above ptr whenever one exists.
  always_comb begin
    gnt_idx = '0;
    any     = |req;
    for (int k = p_n - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt_idx = gw'(k);
      end
    end
    for (int k = p_n - 1; k >= 0; k--) begin
      if (req[k] && (k >= int'(ptr))) begin
        gnt_idx = gw'(k);
      end
    end
  end

endmodule

// File: rtl/x_top_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// x_top_uart_tx_arb
// Packet-level round-robin arbiter sharing one UART transmitter between p_n
// byte-stream requesters. A grant is held from the first byte of a packet up
// to the byte flagged last, or until p_max_len bytes were taken (forced
// release, flagged by a one-cycle o_trunc pulse).
//   i_clk    : clock, rising edge
//   i_rst    : synchronous reset, active-high
//   bus      : x_top_uart_tx_arb_if.slave (requester and transmitter side)
//   o_busy   : a grant is held
//   o_grant  : index of the current or last grantee
//   o_trunc  : one-cycle pulse after a forced release
// Optional feature: define X_TOP_UART_ARB_TAG_EN to send a tag byte
// (ARB_TAG_PREFIX | grantee) ahead of every packet.
// ---------------------------------------------------------------------------
module x_top_uart_tx_arb
  import x_top_uart_arb_pkg::*;
#(
  parameter  int p_n       = 4,
  parameter  int p_max_len = 64,
  localparam int gw        = (p_n > 1) ? $clog2(p_n) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  x_top_uart_tx_arb_if.slave bus,
  output logic               o_busy,
  output logic [gw-1:0]      o_grant,
  output logic               o_trunc
);

  localparam logic [ARB_CNT_W-1:0] cnt_limit = ARB_CNT_W'(p_max_len - 1);
  localparam logic [gw-1:0]        last_idx  = gw'(p_n - 1);

  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [gw-1:0]        ptr;
  logic [gw-1:0]        ptr_nxt;
  logic [gw-1:0]        grant_nxt;
  logic [ARB_CNT_W-1:0] cnt;
  logic [ARB_CNT_W-1:0] cnt_nxt;
  logic                 trunc_nxt;
  logic                 take;
  logic                 valid_mux;
  logic [7:0]           data_mux;
  logic [p_n-1:0]       accept_vec;
  logic [gw-1:0]        pick_idx;
  logic                 pick_any;

  x_top_uart_arb_rr #(
    .p_n (p_n)
  ) u_rr (
    .req     (bus.i_valid),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Next-state and output logic. In DATA the grantee's byte and valid pass
  // straight through to the transmitter and the transmitter's accept is
  // fanned back to the grantee only, so there is no buffering stage. The
  // pointer wrap uses an explicit compare so non power-of-two p_n works.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    grant_nxt  = o_grant;
    cnt_nxt    = cnt;
    trunc_nxt  = 1'b0;
    take       = 1'b0;
    valid_mux  = 1'b0;
    data_mux   = '0;
    accept_vec = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          cnt_nxt   = '0;
`ifdef X_TOP_UART_ARB_TAG_EN
          state_nxt = TAG;
`else
          state_nxt = DATA;
`endif
        end
      end
      TAG: begin
`ifdef X_TOP_UART_ARB_TAG_EN
        valid_mux = 1'b1;
        data_mux  = ARB_TAG_PREFIX | 8'(o_grant);
        if (bus.i_accept) begin
          state_nxt = DATA;
        end
`else
        state_nxt = IDLE;
`endif
      end
      DATA: begin
        valid_mux           = bus.i_valid[o_grant];
        data_mux            = bus.i_data[{o_grant, 3'b000} +: 8];
        take                = bus.i_accept & valid_mux;
        accept_vec[o_grant] = take;
        if (take) begin
          cnt_nxt = cnt + 1'b1;
          if (bus.i_last[o_grant] || (cnt == cnt_limit)) begin
            state_nxt = IDLE;
            ptr_nxt   = (o_grant == last_idx) ? '0 : o_grant + 1'b1;
            trunc_nxt = ~bus.i_last[o_grant];
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; a reset mid-packet simply drops the grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      ptr     <= '0;
      o_grant <= '0;
      cnt     <= '0;
      o_trunc <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      o_grant <= grant_nxt;
      cnt     <= cnt_nxt;
      o_trunc <= trunc_nxt;
    end
  end

  assign o_busy       = (state != IDLE);
  assign bus.o_valid  = valid_mux;
  assign bus.o_data   = data_mux;
  assign bus.o_accept = accept_vec;

endmodule
